// File: rtl/pulp_pwr_ctrl_pkg.sv
// pulp_pwr_ctrl_pkg: shared state encoding, counter width and reload helper
// for the power-domain controller.
package pulp_pwr_ctrl_pkg;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        UP_WAIT = 3'd1,
        RESTORE = 3'd2,
        DEISO   = 3'd3,
        ON      = 3'd4,
        ISO     = 3'd5,
        SAVE    = 3'd6,
        DN_WAIT = 3'd7
    } pwr_state_e;

    // A state held for N cycles loads N-1; the counter expires on reaching zero.
    function automatic logic [CNT_W-1:0] cnt_reload(input int unsigned cycles);
        int unsigned v;
        v = (cycles == 0) ? 0 : cycles - 1;
        return v[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/pulp_pwr_delay_cnt.sv
// pulp_pwr_delay_cnt: loadable down-counter that stops at zero and flags it.
module pulp_pwr_delay_cnt
    import pulp_pwr_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/pulp_pwr_domain_ctrl.sv
// pulp_pwr_domain_ctrl: sequences power switch, retention, level shifters and
// isolation clamps for one switchable domain.
// Optional feature macro: PULP_PWR_RETENTION_EN adds the RESTORE and SAVE
// states with their retention strobes; without it the strobes are tied low.
//
// Handshake: pwr_req_i is a level request sampled only in OFF and ON; a
// started sequence always runs to completion. pwr_sw_en_o/pwr_sw_ack_i is a
// level handshake with the switch chain: ack follows enable after the chain
// settles, and each wait is bounded by SW_TIMEOUT cycles (sticky err_o).
module pulp_pwr_domain_ctrl
    import pulp_pwr_ctrl_pkg::*;
#(
    parameter int unsigned ISO_CYCLES  = 4,
    parameter int unsigned SAVE_CYCLES = 2,
    parameter int unsigned SW_TIMEOUT  = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       pwr_req_i,
    input  logic       pwr_sw_ack_i,
    output logic       pwr_sw_en_o,
    output logic       iso_en_o,
    output logic       ls_en_o,
    output logic       ret_save_o,
    output logic       ret_restore_o,
    output logic       busy_o,
    output logic       pwr_on_o,
    output logic       err_o,
    output pwr_state_e state_o
);

    pwr_state_e       state_q, state_d;
    logic             timeout;
    logic             cnt_load, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;
    logic             sw_en_d, iso_en_d, ls_en_d, busy_d, pwr_on_d;
    logic             sw_en_q, iso_en_q, ls_en_q, busy_q, pwr_on_q, err_q;
`ifdef PULP_PWR_RETENTION_EN
    logic             ret_save_d, ret_restore_d, ret_save_q, ret_restore_q;
`endif

    // Every state entry reloads the shared counter with that state's duration.
    assign cnt_load = (state_d != state_q);

    pulp_pwr_delay_cnt u_delay_cnt (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    // State register plus registered outputs decoded from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= OFF;
            sw_en_q  <= 1'b0;
            iso_en_q <= 1'b1;
            ls_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            pwr_on_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sw_en_q  <= sw_en_d;
            iso_en_q <= iso_en_d;
            ls_en_q  <= ls_en_d;
            busy_q   <= busy_d;
            pwr_on_q <= pwr_on_d;
            err_q    <= err_q | timeout;
        end
    end

`ifdef PULP_PWR_RETENTION_EN
    // Retention strobes are registered alongside the other outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ret_save_q    <= 1'b0;
            ret_restore_q <= 1'b0;
        end else begin
            ret_save_q    <= ret_save_d;
            ret_restore_q <= ret_restore_d;
        end
    end
    assign ret_save_o    = ret_save_q;
    assign ret_restore_o = ret_restore_q;
`else
    assign ret_save_o    = 1'b0;
    assign ret_restore_o = 1'b0;
`endif

    // Next-state logic; switch waits give up after the counter expires.
    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            OFF: begin
                if (pwr_req_i) state_d = UP_WAIT;
            end
            UP_WAIT: begin
                if (pwr_sw_ack_i) begin
`ifdef PULP_PWR_RETENTION_EN
                    state_d = RESTORE;
`else
                    state_d = DEISO;
`endif
                end else if (cnt_zero) begin
                    timeout = 1'b1;
                    state_d = OFF;
                end
            end
`ifdef PULP_PWR_RETENTION_EN
            RESTORE: begin
                if (cnt_zero) state_d = DEISO;
            end
`endif
            DEISO: begin
                if (cnt_zero) state_d = ON;
            end
            ON: begin
                if (!pwr_req_i) state_d = ISO;
            end
            ISO: begin
                if (cnt_zero) begin
`ifdef PULP_PWR_RETENTION_EN
                    state_d = SAVE;
`else
                    state_d = DN_WAIT;
`endif
                end
            end
`ifdef PULP_PWR_RETENTION_EN
            SAVE: begin
                if (cnt_zero) state_d = DN_WAIT;
            end
`endif
            DN_WAIT: begin
                if (!pwr_sw_ack_i) begin
                    state_d = OFF;
                end else if (cnt_zero) begin
                    timeout = 1'b1;
                    state_d = OFF;
                end
            end
            default: state_d = OFF;
        endcase
    end

    // Output decode of the next state and its counter reload value.
    always_comb begin
        sw_en_d      = 1'b0;
        iso_en_d     = 1'b1;
        ls_en_d      = 1'b0;
        busy_d       = 1'b1;
        pwr_on_d     = 1'b0;
        cnt_load_val = '0;
`ifdef PULP_PWR_RETENTION_EN
        ret_save_d    = 1'b0;
        ret_restore_d = 1'b0;
`endif
        case (state_d)
            OFF: busy_d = 1'b0;
            UP_WAIT: begin
                sw_en_d      = 1'b1;
                cnt_load_val = cnt_reload(SW_TIMEOUT);
            end
`ifdef PULP_PWR_RETENTION_EN
            RESTORE: begin
                sw_en_d       = 1'b1;
                ret_restore_d = 1'b1;
                cnt_load_val  = cnt_reload(SAVE_CYCLES);
            end
`endif
            DEISO: begin
                sw_en_d      = 1'b1;
                ls_en_d      = 1'b1;
                cnt_load_val = cnt_reload(ISO_CYCLES);
            end
            ON: begin
                sw_en_d  = 1'b1;
                ls_en_d  = 1'b1;
                iso_en_d = 1'b0;
                busy_d   = 1'b0;
                pwr_on_d = 1'b1;
            end
            ISO: begin
                sw_en_d      = 1'b1;
                ls_en_d      = 1'b1;
                cnt_load_val = cnt_reload(ISO_CYCLES);
            end
`ifdef PULP_PWR_RETENTION_EN
            SAVE: begin
                sw_en_d      = 1'b1;
                ls_en_d      = 1'b1;
                ret_save_d   = 1'b1;
                cnt_load_val = cnt_reload(SAVE_CYCLES);
            end
`endif
            DN_WAIT: cnt_load_val = cnt_reload(SW_TIMEOUT);
            default: busy_d = 1'b0;
        endcase
    end

    assign pwr_sw_en_o = sw_en_q;
    assign iso_en_o    = iso_en_q;
    assign ls_en_o     = ls_en_q;
    assign busy_o      = busy_q;
    assign pwr_on_o    = pwr_on_q;
    assign err_o       = err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pulp_pwr_domain_ctrl.sv
// tb_pulp_pwr_domain_ctrl: table-driven bench for the power-domain controller
// with hand-written sequences for asynchronous reset mid-sequence.
`timescale 1ns/1ps
module tb_pulp_pwr_domain_ctrl;
    import pulp_pwr_ctrl_pkg::*;

    localparam int unsigned ISO_CYCLES  = 4;
    localparam int unsigned SAVE_CYCLES = 2;
    localparam int unsigned SW_TIMEOUT  = 16;
`ifdef PULP_PWR_RETENTION_EN
    localparam bit RET = 1'b1;
`else
    localparam bit RET = 1'b0;
`endif

    // Expected outputs per state: {sw, iso, ls, save, restore, busy, on, err}
    localparam logic [7:0] O_OFF = 8'b0100_0000;
    localparam logic [7:0] O_UPW = 8'b1100_0100;
    localparam logic [7:0] O_RST = 8'b1100_1100;
    localparam logic [7:0] O_DEI = 8'b1110_0100;
    localparam logic [7:0] O_ON  = 8'b1010_0010;
    localparam logic [7:0] O_ISO = 8'b1110_0100;
    localparam logic [7:0] O_SAV = 8'b1111_0100;
    localparam logic [7:0] O_DNW = 8'b0100_0100;

    logic       clk, rst_n, pwr_req, pwr_sw_ack;
    logic       sw_en, iso_en, ls_en, ret_save, ret_restore, busy, pwr_on, err;
    pwr_state_e state;

    typedef struct {
        logic       req;
        logic       ack;
        pwr_state_e st;
        logic [7:0] outs;
    } vec_t;

    vec_t        vec_q[$];
    logic [10:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    pulp_pwr_domain_ctrl #(
        .ISO_CYCLES  (ISO_CYCLES),
        .SAVE_CYCLES (SAVE_CYCLES),
        .SW_TIMEOUT  (SW_TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .pwr_req_i     (pwr_req),
        .pwr_sw_ack_i  (pwr_sw_ack),
        .pwr_sw_en_o   (sw_en),
        .iso_en_o      (iso_en),
        .ls_en_o       (ls_en),
        .ret_save_o    (ret_save),
        .ret_restore_o (ret_restore),
        .busy_o        (busy),
        .pwr_on_o      (pwr_on),
        .err_o         (err),
        .state_o       (state)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] got;
        got = {state, sw_en, iso_en, ls_en, ret_save, ret_restore, busy, pwr_on, err};
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                     name, got[10:8], got[7:0], exp[10:8], exp[7:0]);
        end
    endtask

    function automatic void add(input int n, input logic req, input logic ack,
                                input pwr_state_e st, input logic [7:0] outs,
                                input logic e);
        vec_t v;
        v.req  = req;
        v.ack  = ack;
        v.st   = st;
        v.outs = outs | {7'b0, e};
        for (int i = 0; i < n; i++) vec_q.push_back(v);
    endfunction

    // Driver: each row applies inputs for one cycle, then checks after the edge.
    task automatic run_vectors(input string tag);
        foreach (vec_q[i]) begin
            pwr_req    = vec_q[i].req;
            pwr_sw_ack = vec_q[i].ack;
            exp_q.push_back({vec_q[i].st, vec_q[i].outs});
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", tag, i), exp_q.pop_front());
        end
        vec_q.delete();
    endtask

    initial begin
        rst_n      = 1'b0;
        pwr_req    = 1'b0;
        pwr_sw_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset", {OFF, O_OFF});

        // Power-up with ack three cycles late, then full power-down.
        add(3, 1, 0, UP_WAIT, O_UPW, 0);
        if (RET) add(2, 1, 1, RESTORE, O_RST, 0);
        add(4, 1, 1, DEISO, O_DEI, 0);
        add(2, 1, 1, ON, O_ON, 0);
        add(4, 0, 1, ISO, O_ISO, 0);
        if (RET) add(2, 0, 1, SAVE, O_SAV, 0);
        add(3, 0, 1, DN_WAIT, O_DNW, 0);
        add(3, 0, 0, OFF, O_OFF, 0);
        // Request dropped during DEISO, raised again during ISO: both ignored.
        add(1, 1, 0, UP_WAIT, O_UPW, 0);
        if (RET) add(2, 1, 1, RESTORE, O_RST, 0);
        add(1, 1, 1, DEISO, O_DEI, 0);
        add(3, 0, 1, DEISO, O_DEI, 0);
        add(1, 0, 1, ON, O_ON, 0);
        add(1, 0, 1, ISO, O_ISO, 0);
        add(3, 1, 1, ISO, O_ISO, 0);
        if (RET) add(2, 1, 1, SAVE, O_SAV, 0);
        add(2, 1, 1, DN_WAIT, O_DNW, 0);
        add(1, 1, 0, OFF, O_OFF, 0);
        add(1, 1, 0, UP_WAIT, O_UPW, 0);
        if (RET) add(2, 1, 1, RESTORE, O_RST, 0);
        add(4, 1, 1, DEISO, O_DEI, 0);
        add(1, 1, 1, ON, O_ON, 0);
        // Switch never releases: DN_WAIT times out, err sticks.
        add(4, 0, 1, ISO, O_ISO, 0);
        if (RET) add(2, 0, 1, SAVE, O_SAV, 0);
        add(16, 0, 1, DN_WAIT, O_DNW, 0);
        add(2, 0, 1, OFF, O_OFF, 1);
        // err does not block a new request.
        add(1, 1, 1, UP_WAIT, O_UPW, 1);
        if (RET) add(2, 1, 1, RESTORE, O_RST, 1);
        add(4, 1, 1, DEISO, O_DEI, 1);
        add(1, 1, 1, ON, O_ON, 1);
        add(4, 0, 1, ISO, O_ISO, 1);
        if (RET) add(2, 0, 1, SAVE, O_SAV, 1);
        add(1, 0, 0, DN_WAIT, O_DNW, 1);
        add(1, 0, 0, OFF, O_OFF, 1);
        // Stop one cycle into RESTORE (DEISO without retention).
        add(1, 1, 0, UP_WAIT, O_UPW, 1);
        add(1, 1, 1, RET ? RESTORE : DEISO, RET ? O_RST : O_DEI, 1);
        run_vectors("seq1");

        // Asynchronous reset mid-sequence, away from any clock edge.
        pwr_req    = 1'b0;
        pwr_sw_ack = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {OFF, O_OFF});
        @(posedge clk);
        #1;
        check("held_reset", {OFF, O_OFF});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset", {OFF, O_OFF});

        // Switch never acks: UP_WAIT times out after 16 cycles, then recovery.
        add(16, 1, 0, UP_WAIT, O_UPW, 0);
        add(2, 0, 0, OFF, O_OFF, 1);
        add(2, 1, 0, UP_WAIT, O_UPW, 1);
        if (RET) add(2, 1, 1, RESTORE, O_RST, 1);
        add(4, 1, 1, DEISO, O_DEI, 1);
        add(2, 1, 1, ON, O_ON, 1);
        add(1, 0, 1, ISO, O_ISO, 1);
        run_vectors("seq2");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pulp_pwr_domain_ctrl.md
PULP_PWR_DOMAIN_CTRL -- requirements
Module: pulp_pwr_domain_ctrl

Interface
REQ-001 SHALL have parameter ISO_CYCLES, default 4: cycles the isolation clamp is held around level-shifter enable/disable (1..255).
REQ-002 SHALL have parameter SAVE_CYCLES, default 2: cycles ret_save_o/ret_restore_o are held high (1..255).
REQ-003 SHALL have parameter SW_TIMEOUT, default 255: maximum cycles to wait for the switch acknowledge (1..255).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port pwr_req_i, input, 1 bit: 1 requests domain on, 0 requests off; already synchronous to clk_i.
REQ-007 SHALL have port pwr_sw_ack_i, input, 1 bit: power-switch chain status, 1 = domain supplied; already synchronised.
REQ-008 SHALL have port pwr_sw_en_o, output, 1 bit: power-switch enable.
REQ-009 SHALL have port iso_en_o, output, 1 bit: isolation clamp enable, 1 = clamped.
REQ-010 SHALL have port ls_en_o, output, 1 bit: level-shifter enable.
REQ-011 SHALL have port ret_save_o, output, 1 bit: retention save strobe.
REQ-012 SHALL have port ret_restore_o, output, 1 bit: retention restore strobe.
REQ-013 SHALL have port busy_o, output, 1 bit: 1 while in any transition state.
REQ-014 SHALL have port pwr_on_o, output, 1 bit: 1 only in state ON.
REQ-015 SHALL have port err_o, output, 1 bit: sticky switch-timeout flag.

Function
REQ-016 SHALL implement FSM states OFF, UP_WAIT, RESTORE, DEISO, ON, ISO, SAVE, DN_WAIT; all outputs SHALL be registered and change in the cycle after the state change.
REQ-017 OFF: iso=1, ls=0, sw=0; when pwr_req_i=1, go to UP_WAIT.
REQ-018 UP_WAIT: sw=1, iso=1; on pwr_sw_ack_i=1, go to RESTORE; on SW_TIMEOUT cycles without ack, set err_o and go to OFF.
REQ-019 RESTORE: ret_restore_o=1 for SAVE_CYCLES cycles, then go to DEISO.
REQ-020 DEISO: ls=1, iso=1 for ISO_CYCLES cycles, then go to ON.
REQ-021 ON: iso=0, ls=1, sw=1; when pwr_req_i=0, go to ISO.
REQ-022 ISO: iso=1, ls=1 for ISO_CYCLES cycles, then go to SAVE.
REQ-023 SAVE: ret_save_o=1 for SAVE_CYCLES cycles, then go to DN_WAIT.
REQ-024 DN_WAIT: ls=0, sw=0; on pwr_sw_ack_i=0, go to OFF; on timeout, set err_o and still go to OFF.
REQ-025 pwr_req_i changes SHALL be ignored outside OFF and ON; a sequence always completes, then the request is re-evaluated.
REQ-026 iso_en_o SHALL never be 0 unless ls_en_o=1, pwr_sw_en_o=1 and pwr_sw_ack_i was 1.
REQ-027 err_o SHALL clear only on reset; err_o=1 SHALL NOT block further requests.
REQ-028 A single 8-bit down-counter SHALL serve all timed states; it SHALL reload on every state entry.

Reset
REQ-029 Asserting rst_ni SHALL force state OFF at any time, including mid-sequence.
REQ-030 Reset values: iso=1, ls=0, sw=0, ret_save=0, ret_restore=0, busy=0, pwr_on=0, err=0, counter=0.

Configuration
REQ-031 With macro PULP_PWR_RETENTION_EN defined, the RESTORE and SAVE states SHALL exist.
REQ-032 Without PULP_PWR_RETENTION_EN, UP_WAIT SHALL go directly to DEISO and ISO directly to DN_WAIT; ret_save_o and ret_restore_o SHALL be tied to 0.

Structure
REQ-033 Package pulp_pwr_ctrl_pkg SHALL hold the state enum typedef and the counter width constant (8).
REQ-034 Sub-module pulp_pwr_delay_cnt SHALL implement the loadable down-counter with a zero flag.

Verification (ISO_CYCLES=4, SAVE_CYCLES=2, SW_TIMEOUT=16, macro defined)
REQ-035 Power-up: req=1 with ack returned 3 cycles after sw=1 -> ret_restore_o high 2 cycles, then ls=1 with iso=1 for 4 cycles, then iso=0 and pwr_on_o=1.
REQ-036 Power-down: req=0 from ON -> iso=1 for 4 cycles with ls=1, ret_save_o for 2 cycles, then sw=0 and ls=0; ack drops -> OFF, busy_o=0.
REQ-037 Timeout: req=1 with ack held 0 -> after 16 cycles err_o=1, sw=0, state OFF; a later request with a working ack reaches ON.
REQ-038 Request toggle: req set 1 then 0 during DEISO -> reaches ON (pwr_on_o=1 for 1 cycle), then the down sequence starts.
REQ-039 Reset mid-RESTORE -> outputs take reset values asynchronously; iso_en_o=1 immediately.
REQ-040 Macro undefined: full up/down cycle -> ret strobes stay 0; power-up latency is 2 cycles shorter than with the macro.
